dma_multichannel_sequencer: RTL and testbench
=============================================

// Module: dma_multichannel_sequencer
// PURPOSE
//  N-channel single-transfer DMA sequencer: arbitrates DREQ lines, handles the HRQ/HLDA bus handshake,
//  runs the SI/SO/S1/S2/S3/S4 transfer FSM, and drives address, strobes, DACK and TC.
//  Successor to the fixed 4-channel 8237-style controller; channel count and widths are parametrised.
// PARAMETERS
//  NUM_CH   4   number of DMA channels (2..8)
//  ADDR_W   16  address register / addr_out width
//  COUNT_W  16  word-count width; programmed value N gives N+1 transfers
// PORTS
//  CLK         in   1        clock; all state on posedge
//  RESET       in   1        asynchronous, active-high reset
//  cfg_we      in   1        program channel cfg_ch (accepted only in SI)
//  cfg_ch      in   CH_W     channel index, CH_W=$clog2(NUM_CH)
//  cfg_addr    in   ADDR_W   start address
//  cfg_count   in   COUNT_W  word count (N+1 transfers)
//  cfg_wr_xfer in   1        1: IO->mem (IOR_N+MEMW_N), 0: mem->IO (MEMR_N+IOW_N)
//  rotate_mode in   1        1: rotating priority (macro-dependent, see CONFIGURATION)
//  DREQ        in   NUM_CH   channel requests, active-high, level
//  HLDA        in   1        hold acknowledge from CPU
//  READY       in   1        0 inserts wait states (S3)
//  HRQ         out  1        hold request
//  DACK        out  NUM_CH   one-hot grant, active-high
//  AEN         out  1        address enable
//  ADSTB       out  1        address strobe
//  addr_out    out  ADDR_W   current address of granted channel
//  MEMR_N/MEMW_N/IOR_N/IOW_N out 1  active-low strobes
//  TC          out  1        terminal-count pulse
//  mask        out  NUM_CH   per-channel mask state
// BEHAVIOUR
//  Reset: state=SI; HRQ, DACK, AEN, ADSTB, TC=0; strobes=1; addr_out=0; mask=all 1;
//   address/count regs=0; priority order ch0 highest..ch(NUM_CH-1) lowest.
//  Config: cfg_we in SI loads addr/count/dir for cfg_ch and clears mask[cfg_ch]; ignored in other states.
//   DREQ on the same channel in the same cycle is evaluated the next cycle.
//  SI: any (DREQ & ~mask) -> SO; HRQ=1 registered (1 cycle after DREQ).
//  SO: HRQ held. HLDA=1 -> latch highest-priority active channel -> S1.
//   If no unmasked DREQ remains -> SI, HRQ=0.
//  S1: AEN=1, ADSTB=1, DACK[ch]=1, addr_out=current addr -> S2.
//  S2: ADSTB=0; both strobes for the transfer direction low; READY=1 -> S4, else S3.
//  S3: hold strobes, DACK, AEN while READY=0; READY=1 -> S4.
//  S4: strobes high; addr+1 (wraps at 2^ADDR_W to 0); count-1.
//   If count was 0: TC=1 for this cycle, mask[ch] set, count wraps to all-ones.
//   -> SI; HRQ, AEN, DACK drop on entering SI. One transfer per grant.
//  HLDA drop in S1..S3: -> SI next cycle, all outputs inactive, addr/count unchanged, no TC.
//  DACK is never multi-hot; masked channels never granted; DREQ drop after S1 does not abort.
//  Reset mid-transfer: all outputs reach reset values asynchronously.
// CONFIGURATION
//  DMA_ROTATE_PRIORITY_EN defined: rotate_mode=1 makes the channel just serviced in S4 lowest priority
//   (order rotates); rotate_mode=0 is fixed priority, and the order resets to default when it changes to 0.
//  Undefined: rotate_mode ignored, fixed priority only; rotation logic is not built.
// STRUCTURE
//  dma_seq_pkg: one-hot state enum (SI=6'b000001, SO=6'b000010, S1=6'b000100, S2=6'b001000,
//   S3=6'b010000, S4=6'b100000), ch_idx_t, direction typedef.
//  Sub-module dma_priority_arbiter: DREQ&~mask -> one-hot winner + rotation order register.
// TESTING
//  Fixed priority: cfg ch0..3, DREQ=4'b1110, HLDA=1 -> DACK=4'b0010 at S1, HRQ 1 cycle after DREQ.
//  Count: ch2 cfg_count=1, addr=16'hFFFF, DREQ held -> 2 transfers; addr wraps to 0; TC on 2nd S4; mask[2]=1.
//  Wait states: READY=0 for 3 cycles in S2 -> 3 S3 cycles; strobes held low; S4 follows READY=1.
//  Abort: HLDA drops in S2 -> SI next cycle; strobes=1, DACK=0; addr/count unchanged; no TC.
//  Rotation (macro on, rotate_mode=1): DREQ=4'b1111 -> grants 0,1,2,3,0 in order.
//  Macro off: same stimulus -> always ch0.
//  Reset: assert RESET in S3 -> same edge: HRQ=0, DACK=0, strobes=1, mask=4'b1111, state=SI.

Source files
------------

// File: rtl/dma_seq_pkg.sv
// dma_seq_pkg
//   Shared types for the multichannel DMA sequencer.
//   state_t  : one-hot transfer FSM encoding (SI idle, SO hold request, S1..S4 transfer).
//   ch_idx_t : channel index, wide enough for the largest supported channel count.
//   dir_t    : transfer direction of a channel.
package dma_seq_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [5:0] {
        SI = 6'b000001,
        SO = 6'b000010,
        S1 = 6'b000100,
        S2 = 6'b001000,
        S3 = 6'b010000,
        S4 = 6'b100000
    } state_t;

    typedef logic [$clog2(MAX_CH)-1:0] ch_idx_t;

    typedef enum logic {
        DIR_MEM_TO_IO = 1'b0,   // MEMR_N + IOW_N
        DIR_IO_TO_MEM = 1'b1    // IOR_N + MEMW_N
    } dir_t;

endpackage

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Picks one winner from the unmasked request vector. Priority starts at
//   channel 'base' and walks upward with wrap-around.
//   Build option: DMA_ROTATE_PRIORITY_EN. When defined, base moves to the
//   channel after the one just serviced (advance pulse) while rotate_mode=1,
//   and snaps back to 0 whenever rotate_mode=0. When undefined, base is
//   fixed at 0 and the rotation inputs are ignored.
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   req          : unmasked requests
//   rotate_mode  : rotation enable (only with DMA_ROTATE_PRIORITY_EN)
//   advance      : pulse when a transfer completes
//   served_ch    : channel that completed
//   grant_idx    : index of the winning channel
//   any_req      : at least one request present
module dma_priority_arbiter
    import dma_seq_pkg::*;
#(
    parameter int NUM_CH = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              rotate_mode,
    input  logic              advance,
    input  ch_idx_t           served_ch,
    output ch_idx_t           grant_idx,
    output logic              any_req
);

    ch_idx_t               base;
    logic [2*NUM_CH-1:0]   req_shifted;
    logic [NUM_CH-1:0]     req_rot;
    logic [NUM_CH-1:0]     grant_rot;
    logic [2*NUM_CH-1:0]   grant_wide;
    logic [NUM_CH-1:0]     grant;

`ifdef DMA_ROTATE_PRIORITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
        end else if (!rotate_mode) begin
            base <= '0;
        end else if (advance) begin
            base <= (served_ch == ch_idx_t'(NUM_CH - 1)) ? '0 : served_ch + 1'b1;
        end
    end
`else
    logic unused_rotation;
    assign base            = '0;
    assign unused_rotation = ^{rotate_mode, advance, served_ch};
`endif

    // Rotate requests so bit 0 is the current highest priority, take the
    // lowest set bit, then rotate the one-hot result back into place.
    assign req_shifted = {req, req} >> base;
    assign req_rot     = req_shifted[NUM_CH-1:0];
    assign grant_rot   = req_rot & (~req_rot + 1'b1);
    assign grant_wide  = {grant_rot, grant_rot} << base;
    assign grant       = grant_wide[2*NUM_CH-1:NUM_CH];
    assign any_req     = |req;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) grant_idx = ch_idx_t'(i);
        end
    end

endmodule

// File: rtl/dma_multichannel_sequencer.sv
// dma_multichannel_sequencer
//   N-channel single-transfer DMA sequencer: DREQ arbitration, HRQ/HLDA
//   handshake, SI/SO/S1..S4 transfer FSM, address/strobe/DACK/TC generation.
//   Build option: DMA_ROTATE_PRIORITY_EN enables rotating priority under
//   rotate_mode; without it priority is fixed (ch0 highest).
// Ports
//   CLK, RESET      : clock, asynchronous active-high reset
//   cfg_*           : channel programming, accepted only in SI
//   rotate_mode     : rotating priority select
//   DREQ, HLDA, READY : requests, hold acknowledge, wait-state control
//   HRQ, DACK, AEN, ADSTB, addr_out : bus handshake, grant, address path
//   MEMR_N, MEMW_N, IOR_N, IOW_N     : active-low strobes
//   TC, mask        : terminal-count pulse, per-channel mask
//
// state | meaning
// SI    | idle, accepts configuration
// SO    | HRQ raised, waiting for HLDA
// S1    | address phase, ADSTB pulse, DACK asserted
// S2    | strobes asserted
// S3    | wait state while READY=0
// S4    | strobes released, address/count update, TC on last word
module dma_multichannel_sequencer
    import dma_seq_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int ADDR_W  = 16,
    parameter  int COUNT_W = 16,
    localparam int CH_W    = $clog2(NUM_CH)
)(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic               cfg_wr_xfer,
    input  logic               rotate_mode,
    input  logic [NUM_CH-1:0]  DREQ,
    input  logic               HLDA,
    input  logic               READY,
    output logic               HRQ,
    output logic [NUM_CH-1:0]  DACK,
    output logic               AEN,
    output logic               ADSTB,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               MEMR_N,
    output logic               MEMW_N,
    output logic               IOR_N,
    output logic               IOW_N,
    output logic               TC,
    output logic [NUM_CH-1:0]  mask
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q  [NUM_CH];
    logic [COUNT_W-1:0]  count_q [NUM_CH];
    dir_t                dir_q   [NUM_CH];
    logic [CH_W-1:0]     cur_ch;
    logic [NUM_CH-1:0]   pending;
    logic                any_req;
    ch_idx_t             win_idx;
    logic                busy;
    logic                strobing;
    logic                count_zero;
    dir_t                cur_dir;

    assign pending    = DREQ & ~mask;
    assign count_zero = (count_q[cur_ch] == '0);
    assign cur_dir    = dir_q[cur_ch];

    dma_priority_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk         (CLK),
        .rst         (RESET),
        .req         (pending),
        .rotate_mode (rotate_mode),
        .advance     (state_q == S4),
        .served_ch   (ch_idx_t'(cur_ch)),
        .grant_idx   (win_idx),
        .any_req     (any_req)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= SI;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        HRQ      = 1'b1;
        busy     = 1'b0;
        strobing = 1'b0;
        ADSTB    = 1'b0;
        TC       = 1'b0;
        case (state_q)
            SI: begin
                HRQ = 1'b0;
                if (any_req) state_d = SO;
            end
            SO: begin
                if (!any_req)  state_d = SI;
                else if (HLDA) state_d = S1;
            end
            S1: begin
                busy    = 1'b1;
                ADSTB   = 1'b1;
                state_d = HLDA ? S2 : SI;
            end
            S2: begin
                busy     = 1'b1;
                strobing = 1'b1;
                if (!HLDA)      state_d = SI;
                else if (READY) state_d = S4;
                else            state_d = S3;
            end
            S3: begin
                busy     = 1'b1;
                strobing = 1'b1;
                if (!HLDA)      state_d = SI;
                else if (READY) state_d = S4;
            end
            S4: begin
                busy    = 1'b1;
                TC      = count_zero;
                state_d = SI;
            end
            default: begin
                HRQ     = 1'b0;
                state_d = SI;
            end
        endcase

        AEN      = busy;
        DACK     = busy ? (NUM_CH'(1) << cur_ch) : '0;
        addr_out = busy ? addr_q[cur_ch] : '0;
        MEMR_N   = !(strobing && cur_dir == DIR_MEM_TO_IO);
        IOW_N    = !(strobing && cur_dir == DIR_MEM_TO_IO);
        IOR_N    = !(strobing && cur_dir == DIR_IO_TO_MEM);
        MEMW_N   = !(strobing && cur_dir == DIR_IO_TO_MEM);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mask   <= '1;
            cur_ch <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i]  <= '0;
                count_q[i] <= '0;
                dir_q[i]   <= DIR_MEM_TO_IO;
            end
        end else begin
            if (state_q == SI && cfg_we) begin
                addr_q[cfg_ch]  <= cfg_addr;
                count_q[cfg_ch] <= cfg_count;
                dir_q[cfg_ch]   <= dir_t'(cfg_wr_xfer);
                mask[cfg_ch]    <= 1'b0;
            end
            if (state_q == SO && HLDA && any_req) begin
                cur_ch <= CH_W'(win_idx);
            end
            // Count of zero means this was the last word: the decrement wraps
            // to all-ones and the channel masks itself off.
            if (state_q == S4) begin
                addr_q[cur_ch]  <= addr_q[cur_ch] + 1'b1;
                count_q[cur_ch] <= count_q[cur_ch] - 1'b1;
                if (count_zero) mask[cur_ch] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_multichannel_sequencer.sv
// Directed bench for dma_multichannel_sequencer (4 channels, 16-bit widths).
// Expected grants are pushed into a scoreboard from a small channel model
// when requests are driven and popped at each address phase.
module tb_dma_multichannel_sequencer;

    logic        CLK, RESET, cfg_we, cfg_wr_xfer, rotate_mode, HLDA, READY;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_addr, cfg_count;
    logic [3:0]  DREQ;
    logic        HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N, TC;
    logic [3:0]  DACK, mask;
    logic [15:0] addr_out;
    logic [3:0]  strobes;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  dack;
        logic [15:0] addr;
        logic [3:0]  strb;
        logic        tc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_addr [4];
    logic [15:0] m_cnt  [4];
    logic        m_dir  [4];
    int          rot_seq [5];

    assign strobes = {MEMR_N, MEMW_N, IOR_N, IOW_N};

    dma_multichannel_sequencer #(
        .NUM_CH  (4),
        .ADDR_W  (16),
        .COUNT_W (16)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_addr    (cfg_addr),
        .cfg_count   (cfg_count),
        .cfg_wr_xfer (cfg_wr_xfer),
        .rotate_mode (rotate_mode),
        .DREQ        (DREQ),
        .HLDA        (HLDA),
        .READY       (READY),
        .HRQ         (HRQ),
        .DACK        (DACK),
        .AEN         (AEN),
        .ADSTB       (ADSTB),
        .addr_out    (addr_out),
        .MEMR_N      (MEMR_N),
        .MEMW_N      (MEMW_N),
        .IOR_N       (IOR_N),
        .IOW_N       (IOW_N),
        .TC          (TC),
        .mask        (mask)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cfg(input int ch, input logic [15:0] a, input logic [15:0] c, input logic d);
        cfg_we      = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_addr    = a;
        cfg_count   = c;
        cfg_wr_xfer = d;
        tick();
        cfg_we      = 1'b0;
        m_addr[ch]  = a;
        m_cnt[ch]   = c;
        m_dir[ch]   = d;
    endtask

    task automatic push_exp(input int ch);
        exp_t       e;
        logic [3:0] one;
        one    = 4'b0001;
        e.dack = one << ch;
        e.addr = m_addr[ch];
        e.strb = m_dir[ch] ? 4'b1001 : 4'b0110;
        e.tc   = (m_cnt[ch] == 16'h0000);
        m_addr[ch] = m_addr[ch] + 16'd1;
        m_cnt[ch]  = m_cnt[ch] - 16'd1;
        sb.push_back(e);
    endtask

    task automatic wait_s1(output exp_t e);
        int n;
        n = 0;
        e = '0;
        while (ADSTB !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("s1_reached", ADSTB, 1);
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) e = sb.pop_front();
        check("s1_dack", DACK, e.dack);
        check("s1_addr", addr_out, e.addr);
        check("s1_aen", AEN, 1);
    endtask

    task automatic xfer(input int nwait);
        exp_t e;
        wait_s1(e);
        if (nwait > 0) READY = 1'b0;
        tick();
        check("s2_strobes", strobes, e.strb);
        check("s2_adstb", ADSTB, 0);
        for (int i = 0; i < nwait; i++) begin
            tick();
            check("s3_strobes", strobes, e.strb);
            check("s3_dack", DACK, e.dack);
            if (i == nwait - 1) READY = 1'b1;
        end
        tick();
        check("s4_strobes", strobes, 4'hF);
        check("s4_tc", TC, e.tc);
        check("s4_dack", DACK, e.dack);
    endtask

    initial begin
        exp_t e;
`ifdef DMA_ROTATE_PRIORITY_EN
        rot_seq = '{0, 1, 2, 3, 0};
`else
        rot_seq = '{0, 0, 0, 0, 0};
`endif
        RESET = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_addr = 16'h0;
        cfg_count = 16'h0; cfg_wr_xfer = 1'b0; rotate_mode = 1'b0;
        DREQ = 4'b0000; HLDA = 1'b0; READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hrq", HRQ, 0);
        check("rst_dack", DACK, 0);
        check("rst_mask", mask, 4'hF);
        check("rst_strobes", strobes, 4'hF);
        check("rst_addr", addr_out, 0);
        check("rst_tc_aen", {TC, AEN, ADSTB}, 0);
        RESET = 1'b0;
        tick();

        cfg(0, 16'h1000, 16'h0010, 1'b0);
        cfg(1, 16'h2000, 16'h0005, 1'b1);
        cfg(2, 16'h3000, 16'h0003, 1'b0);
        cfg(3, 16'h4000, 16'h0003, 1'b0);
        check("cfg_mask", mask, 4'h0);

        // fixed priority, HRQ one cycle after DREQ
        DREQ = 4'b1110;
        check("hrq_before", HRQ, 0);
        tick();
        check("hrq_after", HRQ, 1);
        HLDA = 1'b1;
        push_exp(1);
        xfer(0);
        DREQ = 4'b0000; HLDA = 1'b0;
        tick();
        check("si_hrq", HRQ, 0);
        check("si_dack", DACK, 0);
        check("si_aen", AEN, 0);

        // last-word handling with address wrap
        cfg(2, 16'hFFFF, 16'h0001, 1'b0);
        DREQ = 4'b0100; HLDA = 1'b1;
        push_exp(2);
        push_exp(2);
        xfer(0);
        xfer(0);
        tick();
        check("tc_mask", mask, 4'b0100);
        tick();
        tick();
        check("masked_no_hrq", HRQ, 0);
        DREQ = 4'b0000; HLDA = 1'b0;
        tick();

        // wait states
        DREQ = 4'b1000; HLDA = 1'b1;
        push_exp(3);
        xfer(3);
        DREQ = 4'b0000; HLDA = 1'b0;
        tick();

        // abort by HLDA drop in S2
        DREQ = 4'b0001; HLDA = 1'b1;
        begin
            int n;
            n = 0;
            while (ADSTB !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
        end
        check("abort_s1_dack", DACK, 4'b0001);
        tick();
        check("abort_s2_strobes", strobes, 4'b0110);
        HLDA = 1'b0;
        tick();
        check("abort_strobes", strobes, 4'hF);
        check("abort_dack", DACK, 0);
        check("abort_hrq_aen", {HRQ, AEN}, 0);
        check("abort_tc", TC, 0);
        check("abort_mask", mask, 4'b0100);
        HLDA = 1'b1;
        push_exp(0);
        xfer(0);
        DREQ = 4'b0000; HLDA = 1'b0;
        tick();

        // priority rotation (or fixed when the rotation build option is off)
        cfg(2, 16'h3000, 16'h0003, 1'b0);
        rotate_mode = 1'b1;
        DREQ = 4'b1111; HLDA = 1'b1;
        for (int k = 0; k < 5; k++) push_exp(rot_seq[k]);
        for (int k = 0; k < 5; k++) xfer(0);
        DREQ = 4'b0000; HLDA = 1'b0; rotate_mode = 1'b0;
        tick();

        // asynchronous reset during a wait state
        DREQ = 4'b0010; HLDA = 1'b1;
        push_exp(1);
        wait_s1(e);
        READY = 1'b0;
        tick();
        tick();
        check("s3_before_reset", strobes, 4'b1001);
        #2;
        RESET = 1'b1;
        #1;
        check("arst_hrq", HRQ, 0);
        check("arst_dack", DACK, 0);
        check("arst_strobes", strobes, 4'hF);
        check("arst_mask", mask, 4'hF);
        check("arst_aen_addr", {AEN, addr_out}, 0);
        tick();
        RESET = 1'b0;
        READY = 1'b1;
        tick();
        tick();
        check("post_reset_hrq", HRQ, 0);
        DREQ = 4'b0000; HLDA = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
